lea_block_byte_serializer: RTL and testbench
============================================

# lea_block_byte_serializer

Output stage for LEA ciphertext/plaintext blocks. Accepts one 128-bit block over a valid/ready handshake, holds it, and streams it out as 16 bytes over an 8-bit valid/ready interface, byte 0 = Din[7:0] first by default. Sits directly downstream of the 128-bit-to-16-byte split, turning the parallel byte lanes into a byte-serial stream for the host or UART-side interface. Back-to-back blocks stream with zero bubble cycles.

## Interface
- LSB_FIRST, 1, 1: byte order Din[7:0], Din[15:8] … Din[127:120]; 0: Din[127:120] first, down to Din[7:0].
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Din  input  128  block to serialize; sampled only on an accept.
- din_valid  input  1  Din holds a valid block.
- din_ready  output  1  block can be accepted this cycle.
- Dout  output  8  current output byte.
- dout_valid  output  1  Dout holds a valid byte.
- dout_ready  input  1  consumer takes Dout this cycle.
- dout_last  output  1  Dout is the 16th byte of the block.
- busy  output  1  a block is held, i.e. state SEND.

## Operation
- Accept = din_valid & din_ready. Byte transfer = dout_valid & dout_ready.
- States: IDLE (no block held), SEND (block held, bytes pending).
- IDLE: din_ready=1, dout_valid=0. On accept, load the 128-bit hold register, cnt<=0, go to SEND.
- SEND: dout_valid=1. Dout = byte cnt of the hold register in the LSB_FIRST order. dout_last = (cnt==15).
  - Transfer with cnt<15: cnt<=cnt+1.
  - Transfer with cnt==15: when din_valid=1, reload hold register from Din, cnt<=0, stay in SEND. Otherwise go to IDLE, cnt<=0.
- din_ready = (state==IDLE) | (state==SEND & dout_ready & cnt==15). This is combinational from state, cnt and dout_ready. It is forced to 0 while rst_n is low.
- din_valid is ignored in SEND unless din_ready=1. Din is never sampled without an accept.
- Stall: while dout_valid=1 and dout_ready=0, Dout, dout_last and cnt hold stable.
- cnt is 4 bits. It never wraps past 15 without one of the transitions above.
- busy = (state==SEND).

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, cnt=0, hold register=0, Dout=8'h00, dout_valid=0, dout_last=0, busy=0, din_ready=0 during reset. din_ready=1 from the first cycle after rst_n rises.
- Reset mid-block: the held block is discarded. dout_valid drops immediately. No partial resume after release.
- Latency: a block accepted at edge N presents byte 0 with dout_valid=1 in the cycle after edge N.
- Throughput: one byte per cycle with dout_ready held high. 16 cycles per block. A new block is accepted on the same edge as the last byte of the previous one, so there is no gap.
- Dout, dout_valid, dout_last and busy are driven from registers or a mux of registered state. There is no combinational path from Din to Dout.

## Structure
- Shared package lea_pkg holds:
  - LEA_BLOCK_W=128, LEA_BYTE_W=8, LEA_BYTES=16.
  - The serializer state enum {IDLE, SEND}.
- No sub-module. Byte selection uses either a right/left shift of the hold register by 8 each transfer (chosen by LSB_FIRST) or a 16:1 mux indexed by cnt. Both are acceptable.

## Test plan
- Reset, then Din=128'h0F0E0D0C_0B0A0908_07060504_03020100 with din_valid pulsed and dout_ready=1 -> Dout = 00,01,…,0F on 16 consecutive cycles. dout_last=1 only on 0F. Then dout_valid=0 and din_ready=1.
- Same block with LSB_FIRST=0 -> Dout = 0F,0E,…,00.
- Two blocks, A=all 8'hAA and B=all 8'h55, with din_valid held high and dout_ready=1 -> 32 contiguous valid bytes: 16×AA then 16×55. B is accepted on the same edge as A's 16th byte.
- dout_ready low for 5 cycles at cnt=7 -> Dout stays at byte 7 and dout_last stays 0 throughout. Resumes with byte 8. A total of 16 transfers.
- din_valid=1 with a new Din while in SEND at cnt=3 -> din_ready=0 and the held block is unaffected. The new Din is accepted only at the cnt==15 transfer.
- rst_n pulsed low at cnt=9 -> dout_valid=0 and busy=0 immediately. After release, din_ready=1 and the next accepted block starts at byte 0.

Source files
------------

// File: rtl/lea_pkg.sv
// Shared LEA datapath constants and the block serializer state encoding.
package lea_pkg;
  localparam int LEA_BLOCK_W = 128;
  localparam int LEA_BYTE_W  = 8;
  localparam int LEA_BYTES   = 16;

  typedef enum logic {IDLE, SEND} ser_state_e;
endpackage

// File: rtl/lea_block_byte_serializer_if.sv
// Block-in / byte-out handshake bundle for the LEA byte serializer.
interface lea_block_byte_serializer_if;
  import lea_pkg::*;
  logic [LEA_BLOCK_W-1:0] Din;
  logic                   din_valid;
  logic                   din_ready;
  logic [LEA_BYTE_W-1:0]  Dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;

  modport master (output Din, din_valid, dout_ready,
                  input  din_ready, Dout, dout_valid, dout_last);
  modport slave  (input  Din, din_valid, dout_ready,
                  output din_ready, Dout, dout_valid, dout_last);
endinterface

// File: rtl/lea_block_byte_serializer.sv
// Holds one 128-bit LEA block and streams it as 16 bytes; the next block is
// taken on the same edge as the last byte so consecutive blocks have no gap.
module lea_block_byte_serializer
  import lea_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  lea_block_byte_serializer_if.slave bus,
  output logic                       busy
);
  ser_state_e             state;
  logic [3:0]             cnt;
  logic [LEA_BLOCK_W-1:0] hold;
  logic [3:0]             idx;
  logic                   cnt_end;
  logic                   accept;

  assign cnt_end = (cnt == 4'(LEA_BYTES - 1));
  // Gated by rst_n so no block is offered acceptance while reset is held.
  assign bus.din_ready = rst_n & ((state == IDLE) |
                                  ((state == SEND) & bus.dout_ready & cnt_end));
  assign accept = bus.din_valid & bus.din_ready;

  // Byte order chosen once at elaboration; cnt always counts transfers.
  assign idx            = LSB_FIRST ? cnt : ~cnt;
  assign bus.Dout       = (state == SEND) ? hold[{idx, 3'b000} +: LEA_BYTE_W] : '0;
  assign bus.dout_valid = (state == SEND);
  assign bus.dout_last  = (state == SEND) & cnt_end;
  assign busy           = (state == SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold  <= bus.Din;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (bus.dout_ready) begin
            if (!cnt_end) begin
              cnt <= cnt + 4'd1;
            end else begin
              cnt <= '0;
              if (accept) hold  <= bus.Din;
              else        state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lea_block_byte_serializer.sv
// Scoreboard bench: stimulus pushes expected bytes, negedge monitors pop and compare.
module tb_lea_block_byte_serializer;
  import lea_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy_a, busy_b;

  lea_block_byte_serializer_if ia();
  lea_block_byte_serializer_if ib();

  lea_block_byte_serializer #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave), .busy(busy_a));
  lea_block_byte_serializer #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave), .busy(busy_b));

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Block whose byte k (Din[8k+7:8k]) is base+k.
  function automatic logic [127:0] mk(input logic [7:0] base);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic push_a_seq(input logic [7:0] base);
    for (int i = 0; i < 16; i++) qa.push_back({(i == 15), base + 8'(i)});
  endtask

  task automatic push_a_const(input logic [7:0] b);
    for (int i = 0; i < 16; i++) qa.push_back({(i == 15), b});
  endtask

  always @(negedge clk) begin : mon_a
    logic [8:0] e;
    if (rst_n && ia.dout_valid && ia.dout_ready) begin
      if (qa.size() == 0) chk("a_unexpected_byte", {ia.dout_last, ia.Dout}, 9'h1FF);
      else begin
        e = qa.pop_front();
        chk("a_byte{last,data}", {ia.dout_last, ia.Dout}, e);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [8:0] e;
    if (rst_n && ib.dout_valid && ib.dout_ready) begin
      if (qb.size() == 0) chk("b_unexpected_byte", {ib.dout_last, ib.Dout}, 9'h1FF);
      else begin
        e = qb.pop_front();
        chk("b_byte{last,data}", {ib.dout_last, ib.Dout}, e);
      end
    end
  end

  task automatic drain(input bit which_b, input bit contig);
    int k;
    k = 0;
    while (k < 100 && (which_b ? qb.size() : qa.size()) != 0) begin
      @(negedge clk); #1;
      if (contig && (which_b ? qb.size() : qa.size()) != 0) chk("a_contiguous_valid", ia.dout_valid, 1'b1);
      k++;
    end
    chk(which_b ? "b_drain_left" : "a_drain_left", which_b ? qb.size() : qa.size(), 0);
  endtask

  // Counts negedges until din_ready rises with din_valid up, then lets that edge accept.
  task automatic wait_accept_a(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk); #1;
      chk("a_valid_while_waiting", ia.dout_valid, 1'b1);
      if (ia.din_ready) break;
      n++;
    end
    @(posedge clk); #1;
    ia.din_valid = 1'b0;
  endtask

  task automatic send_a(input logic [127:0] d);
    ia.Din = d;
    ia.din_valid = 1'b1;
    @(posedge clk); #1;
    ia.din_valid = 1'b0;
  endtask

  initial begin
    int n;
    ia.Din = '0; ia.din_valid = 1'b0; ia.dout_ready = 1'b1;
    ib.Din = '0; ib.din_valid = 1'b0; ib.dout_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_din_ready", ia.din_ready, 1'b0);
    chk("rst_dout_valid", ia.dout_valid, 1'b0);
    chk("rst_dout_last", ia.dout_last, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_dout", ia.Dout, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_din_ready", ia.din_ready, 1'b1);

    // LSB-first counting block
    for (int i = 0; i < 16; i++) qa.push_back({(i == 15), 8'(i)});
    @(posedge clk); #1;
    send_a(128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("lat_valid_after_accept", ia.dout_valid, 1'b1);
    chk("busy_in_send", busy_a, 1'b1);
    drain(1'b0, 1'b1);
    @(posedge clk); #1;
    chk("idle_dout_valid", ia.dout_valid, 1'b0);
    chk("idle_din_ready", ia.din_ready, 1'b1);
    chk("idle_busy", busy_a, 1'b0);

    // MSB-first instance, same block
    for (int i = 0; i < 16; i++) qb.push_back({(i == 15), 8'(15 - i)});
    ib.Din = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    ib.din_valid = 1'b1;
    @(posedge clk); #1;
    ib.din_valid = 1'b0;
    drain(1'b1, 1'b0);
    @(posedge clk); #1;
    chk("b_idle_dout_valid", ib.dout_valid, 1'b0);

    // Back-to-back AA then 55 with din_valid held
    push_a_const(8'hAA);
    push_a_const(8'h55);
    ia.Din = {16{8'hAA}};
    ia.din_valid = 1'b1;
    @(posedge clk); #1;
    ia.Din = {16{8'h55}};
    wait_accept_a(n);
    chk("b2b_accept_on_16th", n, 15);
    drain(1'b0, 1'b1);
    @(posedge clk); #1;

    // Stall five cycles at byte 7
    push_a_seq(8'h10);
    send_a(mk(8'h10));
    repeat (7) @(posedge clk);
    #1 ia.dout_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_dout", ia.Dout, 8'h17);
      chk("stall_last", ia.dout_last, 1'b0);
      chk("stall_valid", ia.dout_valid, 1'b1);
    end
    @(posedge clk); #1 ia.dout_ready = 1'b1;
    chk("resume_dout", ia.Dout, 8'h17);
    drain(1'b0, 1'b0);
    @(posedge clk); #1;

    // New block offered mid-send is held off until the 16th transfer
    push_a_seq(8'h20);
    push_a_seq(8'h80);
    send_a(mk(8'h20));
    repeat (3) @(posedge clk);
    #1 ia.Din = mk(8'h80); ia.din_valid = 1'b1;
    #1;
    chk("midsend_din_ready", ia.din_ready, 1'b0);
    chk("midsend_held_byte", ia.Dout, 8'h23);
    wait_accept_a(n);
    chk("midsend_accept_at_cnt15", n, 12);
    drain(1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset mid-block at byte 9
    push_a_seq(8'h40);
    send_a(mk(8'h40));
    repeat (9) @(posedge clk);
    #1 chk("pre_rst_dout", ia.Dout, 8'h49);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout_valid", ia.dout_valid, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    chk("midrst_din_ready", ia.din_ready, 1'b0);
    qa.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_din_ready", ia.din_ready, 1'b1);
    chk("rel_dout_valid", ia.dout_valid, 1'b0);
    push_a_seq(8'h60);
    @(posedge clk); #1;
    send_a(mk(8'h60));
    drain(1'b0, 1'b1);
    @(posedge clk); #1;
    chk("final_idle", ia.dout_valid, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
